mult_arbiter_taint: RTL and testbench
=====================================

MULT_ARBITER_TAINT -- requirements
Module: mult_arbiter_taint

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, giving the operand width of the shared multiplier.
REQ-002 SHALL have ports: clk input 1, the single clock, all state on rising edge.
REQ-003 SHALL have ports: rst input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: req0, req1 input 1 each, requester level requests, held until grant; req0_t, req1_t input 1 each, their taint.
REQ-005 SHALL have ports: a0, b0, a1, b1 input WIDTH each, requester operands; a0_t, b0_t, a1_t, b1_t input 1 each, their taint.
REQ-006 SHALL have ports: gnt0, gnt1 output 1 each, grant pulses; gnt_t output 1, grant taint.
REQ-007 SHALL have ports: done0, done1 output 1 each, completion pulses; done_t output 1, completion taint.
REQ-008 SHALL have ports: product output 2*WIDTH, result of the granted requester's multiply; product_t output 1, its taint.
REQ-009 SHALL have ports: busy output 1, high outside IDLE.
REQ-010 SHALL have ports: m_start, m_multiplier (WIDTH), m_multiplicand (WIDTH) outputs to the multiplier; m_start_t, m_multiplier_t, m_multiplicand_t outputs 1 each, their taint.
REQ-011 SHALL have ports: m_product input 2*WIDTH, m_done input 1, from the multiplier; m_product_t, m_done_t input 1 each, their taint.

Function
REQ-012 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-013 IDLE: if req0|req1 on an edge, SHALL select a requester, latch its a/b into operand registers, move to START; else stay.
REQ-014 START: SHALL drive gnt<sel>=1 and m_start=1 for exactly one cycle, then go to WAIT.
REQ-015 WAIT: SHALL hold operands stable on m_multiplier/m_multiplicand; on m_done=1, SHALL latch m_product into the product register and go to DONE.
REQ-016 DONE: SHALL drive done<sel>=1 for exactly one cycle, then go to IDLE; product SHALL hold its value until the next DONE.
REQ-017 Requests seen outside IDLE SHALL be ignored; a req still high in IDLE after DONE SHALL be re-arbitrated normally.
REQ-018 Fixed overhead: m_start 1 cycle after the request edge; done 1 cycle after m_done; IDLE re-entered 2 cycles after m_done.
REQ-019 Arbitration timing SHALL depend only on req0/req1, never on operand values.
REQ-020 Taint register sel_t SHALL load req0_t|req1_t at arbitration; gnt_t=m_start_t=sel_t during START.
REQ-021 m_multiplier_t SHALL be a<sel>_t|sel_t, and m_multiplicand_t SHALL be b<sel>_t|sel_t, latched with the operands.
REQ-022 In WAIT, sel_t SHALL OR in m_done_t each cycle; at latch, product_t SHALL take m_product_t|sel_t; done_t=sel_t during DONE.
REQ-023 On DONE->IDLE, sel_t SHALL clear (kill: constant-time reconvergence); product_t SHALL persist with product.
REQ-024 All taint outputs SHALL be 0 when their data/control output is not asserted, except product_t.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, with all outputs, operand/product registers, sel, sel_t, and rr pointer at 0, at any state including mid-WAIT.
REQ-026 Following reset release, the first arbitration SHALL occur no earlier than the first rising edge with rst high.

Configuration
REQ-027 Macro MULT_ARB_RR_EN defined: SHALL use round-robin, with a pointer toggling after each grant; on simultaneous requests the non-last-granted requester wins, and requester 0 wins first after reset.
REQ-028 Macro MULT_ARB_RR_EN undefined: SHALL use fixed priority, with req0 always winning ties and no pointer register.

Verification
REQ-029 Single request: req0=1, a0=3, b0=5, m_done 4 cycles after m_start returning 15 -> gnt0 one cycle, done0 one cycle, product=15, all taints 0.
REQ-030 Simultaneous requests: req0=req1=1 held -> with RR: grants 0,1,0,1; without RR: grants always 0.
REQ-031 Taint: req1_t=1, req0 only -> gnt_t=1, m_multiplier_t=1, done_t=1, product_t=1, then sel_t=0 in the next IDLE.
REQ-032 Operand taint: req0, a0_t=1, m_product_t=1 -> m_multiplier_t=1, m_multiplicand_t=0, product_t=1.
REQ-033 Reset mid-WAIT: rst low for 1 cycle -> busy=0, no done pulse, product=0; a fresh req0 is then served normally.
REQ-034 Request during busy: req1 pulsed only during WAIT -> ignored, with no gnt1 ever.

Source files
------------

// File: rtl/mult_arbiter_taint.sv
// Two-requester arbiter in front of a shared WIDTH x WIDTH multiplier, with one-bit taint tracking.
// Define MULT_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 wins).
module mult_arbiter_taint #(
  parameter int WIDTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               req0_t,
  input  logic               req1_t,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               a0_t,
  input  logic               b0_t,
  input  logic               a1_t,
  input  logic               b1_t,
  output logic               gnt0,
  output logic               gnt1,
  output logic               gnt_t,
  output logic               done0,
  output logic               done1,
  output logic               done_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               busy,
  output logic               m_start,
  output logic [WIDTH-1:0]   m_multiplier,
  output logic [WIDTH-1:0]   m_multiplicand,
  output logic               m_start_t,
  output logic               m_multiplier_t,
  output logic               m_multiplicand_t,
  input  logic [2*WIDTH-1:0] m_product,
  input  logic               m_done,
  input  logic               m_product_t,
  input  logic               m_done_t
);

  // state | meaning
  // IDLE  | no transaction; arbitrate on any request
  // START | one-cycle grant and multiplier start pulse
  // WAIT  | operands held on the multiplier, waiting for m_done
  // DONE  | one-cycle completion pulse, product register valid
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               sel_t_q, sel_t_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               opa_t_q, opa_t_d;
  logic               opb_t_q, opb_t_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               prod_t_q, prod_t_d;
  logic               any_req;
  logic               arb_sel;
  logic               arb_taint;

  assign any_req   = req0 | req1;
  assign arb_taint = req0_t | req1_t;

`ifdef MULT_ARB_RR_EN
  // rr_q names the requester that wins a tie; it always points away from the last winner
  logic rr_q, rr_d;

  always_comb begin
    if (req0 && req1) arb_sel = rr_q;
    else              arb_sel = ~req0;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) rr_d = ~arb_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`else
  assign arb_sel = ~req0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (m_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    sel_t_d  = sel_t_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opa_t_d  = opa_t_q;
    opb_t_d  = opb_t_q;
    prod_d   = prod_q;
    prod_t_d = prod_t_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = arb_sel;
          sel_t_d = arb_taint;
          opa_d   = arb_sel ? a1 : a0;
          opb_d   = arb_sel ? b1 : b0;
          opa_t_d = (arb_sel ? a1_t : a0_t) | arb_taint;
          opb_t_d = (arb_sel ? b1_t : b0_t) | arb_taint;
        end
      end
      WAIT: begin
        sel_t_d = sel_t_q | m_done_t;
        if (m_done) begin
          prod_d   = m_product;
          prod_t_d = m_product_t | sel_t_q;
        end
      end
      // control taint is dropped on return to IDLE so it cannot leak into the next transaction
      DONE:    sel_t_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q    <= 1'b0;
      sel_t_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      opa_t_q  <= 1'b0;
      opb_t_q  <= 1'b0;
      prod_q   <= '0;
      prod_t_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      sel_t_q  <= sel_t_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opa_t_q  <= opa_t_d;
      opb_t_q  <= opb_t_d;
      prod_q   <= prod_d;
      prod_t_q <= prod_t_d;
    end
  end

  always_comb begin
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    gnt_t            = 1'b0;
    m_start          = 1'b0;
    m_start_t        = 1'b0;
    m_multiplier_t   = 1'b0;
    m_multiplicand_t = 1'b0;
    done0            = 1'b0;
    done1            = 1'b0;
    done_t           = 1'b0;
    case (state_q)
      START: begin
        gnt0             = ~sel_q;
        gnt1             = sel_q;
        gnt_t            = sel_t_q;
        m_start          = 1'b1;
        m_start_t        = sel_t_q;
        m_multiplier_t   = opa_t_q;
        m_multiplicand_t = opb_t_q;
      end
      WAIT: begin
        m_multiplier_t   = opa_t_q;
        m_multiplicand_t = opb_t_q;
      end
      DONE: begin
        done0  = ~sel_q;
        done1  = sel_q;
        done_t = sel_t_q;
      end
      default: ;
    endcase
  end

  assign m_multiplier   = opa_q;
  assign m_multiplicand = opb_q;
  assign product        = prod_q;
  assign product_t      = prod_t_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter_taint.sv
// Directed scoreboard bench for mult_arbiter_taint; the bench models the external multiplier.
module tb_mult_arbiter_taint;
  localparam int W = 16;

  logic           clk, rst;
  logic           req0, req1, req0_t, req1_t;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           a0_t, b0_t, a1_t, b1_t;
  logic           gnt0, gnt1, gnt_t, done0, done1, done_t;
  logic [2*W-1:0] product;
  logic           product_t, busy;
  logic           m_start, m_start_t, m_multiplier_t, m_multiplicand_t;
  logic [W-1:0]   m_multiplier, m_multiplicand;
  logic [2*W-1:0] m_product;
  logic           m_done, m_product_t, m_done_t;

  int checks = 0;
  int errors = 0;
  int gnt1_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic           sel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           at;
    logic           bt;
    logic           st;
    logic [2*W-1:0] p;
  } exp_t;
  exp_t sb[$];

  mult_arbiter_taint #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req0_t(req0_t), .req1_t(req1_t),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .a0_t(a0_t), .b0_t(b0_t), .a1_t(a1_t), .b1_t(b1_t),
    .gnt0(gnt0), .gnt1(gnt1), .gnt_t(gnt_t),
    .done0(done0), .done1(done1), .done_t(done_t),
    .product(product), .product_t(product_t), .busy(busy),
    .m_start(m_start), .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
    .m_start_t(m_start_t), .m_multiplier_t(m_multiplier_t), .m_multiplicand_t(m_multiplicand_t),
    .m_product(m_product), .m_done(m_done), .m_product_t(m_product_t), .m_done_t(m_done_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gnt1 === 1'b1) gnt1_cnt++;
    if (done0 === 1'b1 || done1 === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input logic s);
    exp_t e;
    e.sel = s;
    e.st  = req0_t | req1_t;
    e.a   = s ? a1 : a0;
    e.b   = s ? b1 : b0;
    e.at  = (s ? a1_t : a0_t) | e.st;
    e.bt  = (s ? b1_t : b0_t) | e.st;
    e.p   = {{W{1'b0}}, e.a} * {{W{1'b0}}, e.b};
    sb.push_back(e);
  endtask

  // One full transaction: grant, WAIT for lat cycles, multiplier answer, completion.
  task automatic serve(input int lat, input logic mdt, input logic mpt,
                       input logic drop, input logic pulse1);
    exp_t e;
    int n;
    n = 0;
    while (m_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", m_start, 1'b1);
    if (m_start !== 1'b1) return;
    chk("sb_empty", sb.size() == 0, 1'b0);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("gnt0", gnt0, !e.sel);
    chk("gnt1", gnt1, e.sel);
    chk("gnt_t", gnt_t, e.st);
    chk("m_start_t", m_start_t, e.st);
    chk("m_multiplier", m_multiplier, e.a);
    chk("m_multiplicand", m_multiplicand, e.b);
    chk("m_multiplier_t", m_multiplier_t, e.at);
    chk("m_multiplicand_t", m_multiplicand_t, e.bt);
    if (drop) begin
      req0 = 0; req1 = 0; req0_t = 0; req1_t = 0;
      a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;
    end
    @(negedge clk);
    chk("gnt_one_cycle", {gnt0, gnt1, m_start}, 3'b000);
    chk("busy_wait", busy, 1'b1);
    chk("hold_multiplier", m_multiplier, e.a);
    chk("hold_multiplier_t", m_multiplier_t, e.at);
    if (pulse1) req1 = 1;
    repeat (lat - 1) @(negedge clk);
    if (pulse1) req1 = 0;
    m_done = 1; m_done_t = mdt; m_product_t = mpt;
    m_product = m_multiplier * m_multiplicand;
    @(negedge clk);
    m_done = 0; m_done_t = 0; m_product_t = 0; m_product = '1;
    chk("done0", done0, !e.sel);
    chk("done1", done1, e.sel);
    chk("done_t", done_t, e.st | mdt);
    chk("product", product, e.p);
    chk("product_t", product_t, mpt | e.st);
    @(negedge clk);
    chk("done_one_cycle", {done0, done1, done_t}, 3'b000);
    chk("busy_idle", busy, 1'b0);
    chk("product_hold", product, e.p);
    chk("product_t_hold", product_t, mpt | e.st);
    chk("idle_operand_taint", {m_multiplier_t, m_multiplicand_t}, 2'b00);
  endtask

  initial begin
    int n;
    int g;
    int d;
    rst = 0; req0 = 0; req1 = 0; req0_t = 0; req1_t = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;
    m_product = 0; m_done = 0; m_product_t = 0; m_done_t = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", {gnt0, gnt1, gnt_t, done0, done1, done_t, m_start, m_start_t}, 8'h00);
    chk("rst_product", product, 0);
    chk("rst_product_t", product_t, 1'b0);
    chk("rst_operands", {m_multiplier, m_multiplicand}, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_no_req", busy, 1'b0);

    // simultaneous held requests straight out of reset
    a0 = 2; b0 = 3; a1 = 4; b1 = 5;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_ARB_RR_EN
      push_exp(i[0]);
`else
      push_exp(1'b0);
`endif
    end
    for (int i = 0; i < 4; i++) serve(2, 1'b0, 1'b0, 1'b0, 1'b0);
    req0 = 0; req1 = 0;

    // single request, 4-cycle multiplier
    a0 = 3; b0 = 5; req0 = 1;
    push_exp(1'b0);
    serve(4, 1'b0, 1'b0, 1'b1, 1'b0);

    // request taint on the idle requester still taints the whole transaction
    a0 = 6; b0 = 7; req0 = 1; req1_t = 1;
    push_exp(1'b0);
    serve(3, 1'b0, 1'b0, 1'b1, 1'b0);

    a0 = 10; b0 = 11; req0 = 1;
    push_exp(1'b0);
    serve(2, 1'b0, 1'b0, 1'b1, 1'b0);

    // operand and product taint
    a0 = 9; b0 = 9; a0_t = 1; req0 = 1;
    push_exp(1'b0);
    serve(3, 1'b1, 1'b1, 1'b1, 1'b0);

    a1 = 12; b1 = 13; req1 = 1;
    push_exp(1'b1);
    serve(2, 1'b0, 1'b0, 1'b1, 1'b0);

    // req1 pulsed only while the multiplier is busy
    g = gnt1_cnt;
    a0 = 5; b0 = 6; req0 = 1;
    push_exp(1'b0);
    serve(4, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_req_ignored", busy, 1'b0);
    chk("no_gnt1", gnt1_cnt, g);

    // reset in the middle of WAIT
    d = done_cnt;
    a0 = 7; b0 = 9; req0 = 1;
    n = 0;
    while (m_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_start", m_start, 1'b1);
    req0 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("midwait_rst_busy", busy, 1'b0);
    chk("midwait_rst_product", product, 0);
    chk("midwait_rst_operand", m_multiplier, 0);
    @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("midwait_no_done", done_cnt, d);
    chk("midwait_idle", busy, 1'b0);

    a0 = 8; b0 = 8; req0 = 1;
    push_exp(1'b0);
    serve(1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
